phase_sequencer: RTL and testbench

Parametrised instruction-phase controller for the stack CPU. It generalises the fixed fetch/decode → execute → return loop to NUM_PHASES phases. Each phase is a one-cycle enable pulse followed by a done handshake from the owning unit. Adds single-step mode, a per-phase timeout fault, a retired-instruction counter, and a clearable halt/fault state. It sits in the CPU top and drives the enables of the fetch/decode, execute and any later units.

---
 rtl/phase_sequencer.sv | 125 ++++++++++++
 tb/tb_phase_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// Instruction-phase controller: walks NUM_PHASES enable/done handshakes per instruction,
// with single-step issue, per-phase WAIT timeout, retired-instruction count and halt/fault hold.
//
// state  | meaning
// IDLE   | waiting for run (and step when step_mode=1)
// ISSUE  | one-cycle phase_en[k] pulse, WAIT timer cleared
// WAIT   | waiting for phase_done from unit k, timer running
// RETIRE | instruction complete, retired count bumped, exit_req sampled
// HALT   | stopped by exit_req, held until clr
// FAULT  | phase k exceeded TIMEOUT WAIT cycles, held until clr
module phase_sequencer #(
   parameter int NUM_PHASES = 3,
   parameter int CNT_W      = 16,
   parameter int TIMEOUT    = 255
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          run,
   input  logic                          step_mode,
   input  logic                          step,
   input  logic                          clr,
   input  logic                          phase_done,
   input  logic                          exit_req,
   output logic [NUM_PHASES-1:0]         phase_en,
   output logic [$clog2(NUM_PHASES)-1:0] phase_idx,
   output logic                          busy,
   output logic                          halted,
   output logic                          timeout_err,
   output logic [CNT_W-1:0]              retired
);

   localparam int                    IDX_W = $clog2(NUM_PHASES);
   localparam logic [IDX_W-1:0]      LAST  = IDX_W'(NUM_PHASES - 1);
   localparam logic [15:0]           TO_M1 = 16'(TIMEOUT - 1);
   localparam logic [NUM_PHASES-1:0] ONE   = NUM_PHASES'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RETIRE,
      S_HALT,
      S_FAULT
   } state_t;

   state_t           state, state_d;
   logic [IDX_W-1:0] k, k_d;
   logic [15:0]      timer, timer_d;
   logic [CNT_W-1:0] retired_d;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= S_IDLE;
         k       <= '0;
         timer   <= '0;
         retired <= '0;
      end else begin
         state   <= state_d;
         k       <= k_d;
         timer   <= timer_d;
         retired <= retired_d;
      end
   end

   always_comb begin
      state_d   = state;
      k_d       = k;
      timer_d   = timer;
      retired_d = retired;
      case (state)
         S_IDLE: begin
            if (run && (!step_mode || step)) begin
               state_d = S_ISSUE;
               k_d     = '0;
            end
         end
         S_ISSUE: begin
            timer_d = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            timer_d = timer + 16'd1;
            // a done arriving on the final allowed cycle takes priority over the fault
            if (phase_done) begin
               if (k == LAST) begin
                  state_d = S_RETIRE;
               end else begin
                  k_d     = k + 1'b1;
                  state_d = S_ISSUE;
               end
            end else if ((TIMEOUT != 0) && (timer == TO_M1)) begin
               state_d = S_FAULT;
            end
         end
         S_RETIRE: begin
            retired_d = retired + 1'b1;
            k_d       = '0;
            if (exit_req) begin
               state_d = S_HALT;
            end else if (run && !step_mode) begin
               state_d = S_ISSUE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_HALT, S_FAULT: begin
            if (clr) begin
               state_d = S_IDLE;
               k_d     = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            k_d     = '0;
         end
      endcase
   end

   assign phase_en    = (state == S_ISSUE) ? (ONE << k) : '0;
   assign phase_idx   = k;
   assign busy        = (state == S_ISSUE) || (state == S_WAIT) || (state == S_RETIRE);
   assign halted      = (state == S_HALT);
   assign timeout_err = (state == S_FAULT);

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: cycle-timed scenarios plus randomized done
// latencies checked against an arithmetic timing model of the instruction sequence.
module tb_phase_sequencer;

   localparam int NP = 3;
   localparam int CW = 4;
   localparam int TO = 5;

   logic          clk = 1'b0;
   logic          rstn, run, step_mode, step, clr, phase_done, exit_req;
   logic [NP-1:0] phase_en;
   logic [1:0]    phase_idx;
   logic          busy, halted, timeout_err;
   logic [CW-1:0] retired;

   int n_checks = 0;
   int n_fail   = 0;

   // unit responder: done arrives dly cycles after each enable pulse (0 = never)
   int dly_mode = 0;
   int fix_dly  = 1;
   int dly_arr[64];
   int dly_idx  = 0;
   int cd       = 0;

   phase_sequencer #(.NUM_PHASES(NP), .CNT_W(CW), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .run         (run),
      .step_mode   (step_mode),
      .step        (step),
      .clr         (clr),
      .phase_done  (phase_done),
      .exit_req    (exit_req),
      .phase_en    (phase_en),
      .phase_idx   (phase_idx),
      .busy        (busy),
      .halted      (halted),
      .timeout_err (timeout_err),
      .retired     (retired)
   );

   always #5 clk = ~clk;

   always @(negedge clk or negedge rstn) begin
      if (!rstn) begin
         cd         = 0;
         phase_done = 1'b0;
      end else begin
         phase_done = 1'b0;
         if (cd > 0) begin
            cd = cd - 1;
            if (cd == 0) phase_done = 1'b1;
         end
         if (phase_en != '0 && dly_mode != 0) begin
            cd      = (dly_mode == 1) ? fix_dly : dly_arr[dly_idx];
            dly_idx = dly_idx + 1;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // returns at the negedge where rstn was released (t=0 of each scenario)
   task automatic do_reset();
      @(negedge clk);
      rstn      = 1'b0;
      run       = 1'b0;
      step_mode = 1'b0;
      step      = 1'b0;
      clr       = 1'b0;
      exit_req  = 1'b0;
      dly_mode  = 0;
      dly_idx   = 0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   function automatic logic [NP-1:0] free_en(input int t);
      // back-to-back with done in the first WAIT cycle: pulses at offsets 0,2,4 of a 7-cycle period
      int m;
      m = (t - 1) % 7;
      if (m == 0) return 3'b001;
      if (m == 2) return 3'b010;
      if (m == 4) return 3'b100;
      return 3'b000;
   endfunction

   task automatic test_reset();
      #3 rstn = 1'b0;
      #1;
      n_checks++; if (phase_en !== 3'b000) begin n_fail++; $display("FAIL reset_phase_en: got %b want 000", phase_en); end
      n_checks++; if (phase_idx !== 2'd0) begin n_fail++; $display("FAIL reset_phase_idx: got %0d want 0", phase_idx); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
      n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
      n_checks++; if (retired !== 4'd0) begin n_fail++; $display("FAIL reset_retired: got %0d want 0", retired); end
      do_reset();
      repeat (3) @(negedge clk);
      n_checks++; if (phase_en !== 3'b000 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_hold: got en=%b busy=%b want 000/0", phase_en, busy); end
   endtask

   task automatic test_free_run();
      do_reset();
      dly_mode = 1; fix_dly = 1; run = 1'b1;
      for (int t = 1; t <= 71; t++) begin
         @(negedge clk);
         n_checks++; if (phase_en !== free_en(t)) begin n_fail++; $display("FAIL free_run_en t=%0d: got %b want %b", t, phase_en, free_en(t)); end
      end
      n_checks++; if (retired !== 4'd10) begin n_fail++; $display("FAIL free_run_retired: got %0d want 10", retired); end
   endtask

   task automatic test_random_run();
      int n, c, d, j, stop_t, last_t, cnt;
      int exp_en[256];
      int exp_idx[256];
      int ret_t[8];
      n = $urandom_range(3, 6);
      for (int u = 0; u < 256; u++) begin exp_en[u] = 0; exp_idx[u] = -1; end
      c = 1; j = 0; stop_t = 1;
      for (int i = 0; i < n; i++) begin
         if (i == n - 1) stop_t = c;
         for (int p = 0; p < NP; p++) begin
            d = $urandom_range(1, TO);
            dly_arr[j] = d;
            exp_en[c] = 1 << p;
            for (int u = c; u <= c + d; u++) exp_idx[u] = p;
            c = c + 1 + d;
            j++;
         end
         ret_t[i] = c;
         c = c + 1;
      end
      last_t = ret_t[n-1];
      do_reset();
      dly_mode = 2; run = 1'b1;
      for (int t = 1; t <= last_t + 6; t++) begin
         @(negedge clk);
         cnt = 0;
         for (int i = 0; i < n; i++) if (ret_t[i] < t) cnt++;
         n_checks++; if (phase_en !== NP'(exp_en[t])) begin n_fail++; $display("FAIL rand_en t=%0d: got %b want %b", t, phase_en, NP'(exp_en[t])); end
         if (exp_idx[t] >= 0) begin
            n_checks++; if (phase_idx !== 2'(exp_idx[t])) begin n_fail++; $display("FAIL rand_idx t=%0d: got %0d want %0d", t, phase_idx, exp_idx[t]); end
         end
         n_checks++; if (retired !== CW'(cnt)) begin n_fail++; $display("FAIL rand_retired t=%0d: got %0d want %0d", t, retired, cnt % 16); end
         n_checks++; if (busy !== (t <= last_t)) begin n_fail++; $display("FAIL rand_busy t=%0d: got %b want %b", t, busy, (t <= last_t)); end
         if (t == stop_t) run = 1'b0;
      end
   endtask

   task automatic test_step_mode();
      logic [NP-1:0] exp;
      do_reset();
      dly_mode = 1; fix_dly = 1; step_mode = 1'b1; run = 1'b1; step = 1'b1;
      for (int t = 1; t <= 30; t++) begin
         @(negedge clk);
         exp = 3'b000;
         if (t == 1 || t == 3 || t == 5) exp = 3'b001 << ((t - 1) / 2);
         if (t == 13 || t == 15 || t == 17) exp = 3'b001 << ((t - 13) / 2);
         n_checks++; if (phase_en !== exp) begin n_fail++; $display("FAIL step_en t=%0d: got %b want %b", t, phase_en, exp); end
         if (t == 10) begin
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL step_idle_gap: got busy=%b want 0", busy); end
         end
         step = (t == 3 || t == 12);
      end
      n_checks++; if (retired !== 4'd2) begin n_fail++; $display("FAIL step_retired: got %0d want 2", retired); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL step_end_busy: got %b want 0", busy); end
   endtask

   task automatic test_exit();
      do_reset();
      dly_mode = 1; fix_dly = 1; run = 1'b1;
      for (int t = 1; t <= 48; t++) begin
         @(negedge clk);
         if (t <= 28) begin
            n_checks++; if (phase_en !== free_en(t)) begin n_fail++; $display("FAIL exit_run_en t=%0d: got %b want %b", t, phase_en, free_en(t)); end
         end else begin
            n_checks++; if (phase_en !== 3'b000 || halted !== 1'b1 || busy !== 1'b0) begin
               n_fail++; $display("FAIL exit_halt_hold t=%0d: got en=%b halted=%b busy=%b want 000/1/0", t, phase_en, halted, busy);
            end
         end
         if (t == 29 || t == 48) begin
            n_checks++; if (retired !== 4'd4) begin n_fail++; $display("FAIL exit_retired t=%0d: got %0d want 4", t, retired); end
         end
         exit_req = (t == 10 || t == 28);
         clr      = (t == 6 || t == 48);
      end
      @(negedge clk);
      clr = 1'b0;
      n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL exit_clr_halted: got %b want 0", halted); end
      n_checks++; if (retired !== 4'd4) begin n_fail++; $display("FAIL exit_clr_retired: got %0d want 4", retired); end
      @(negedge clk);
      n_checks++; if (phase_en !== 3'b001 || phase_idx !== 2'd0) begin n_fail++; $display("FAIL exit_resume: got en=%b idx=%0d want 001/0", phase_en, phase_idx); end
   endtask

   task automatic test_timeout();
      do_reset();
      dly_arr[0] = 1; dly_arr[1] = 0; dly_mode = 2; run = 1'b1;
      for (int t = 1; t <= 9; t++) begin
         @(negedge clk);
         if (t == 8) begin
            n_checks++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL to_before: got err=%b busy=%b want 0/1", timeout_err, busy); end
         end
      end
      n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_fault: got %b want 1", timeout_err); end
      n_checks++; if (phase_idx !== 2'd1) begin n_fail++; $display("FAIL to_idx: got %0d want 1", phase_idx); end
      n_checks++; if (busy !== 1'b0 || phase_en !== 3'b000) begin n_fail++; $display("FAIL to_quiet: got busy=%b en=%b want 0/000", busy, phase_en); end
      run = 1'b0;
      repeat (5) @(negedge clk);
      n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_hold: got %b want 1", timeout_err); end
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      n_checks++; if (timeout_err !== 1'b0 || phase_idx !== 2'd0 || retired !== 4'd0) begin
         n_fail++; $display("FAIL to_clr: got err=%b idx=%0d ret=%0d want 0/0/0", timeout_err, phase_idx, retired);
      end
      do_reset();
      dly_arr[0] = 1; dly_arr[1] = TO; dly_arr[2] = 1; dly_mode = 2; run = 1'b1;
      for (int t = 1; t <= 12; t++) begin
         @(negedge clk);
         if (t == 1) run = 1'b0;
         if (t == 9) begin
            n_checks++; if (phase_en !== 3'b100 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_edge_done: got en=%b err=%b want 100/0", phase_en, timeout_err); end
         end
      end
      n_checks++; if (retired !== 4'd1 || timeout_err !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL to_edge_retire: got ret=%0d err=%b busy=%b want 1/0/0", retired, timeout_err, busy);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      dly_mode = 1; fix_dly = 1; run = 1'b1;
      repeat (27) @(negedge clk);
      n_checks++; if (retired !== 4'd3 || phase_idx !== 2'd2 || busy !== 1'b1) begin
         n_fail++; $display("FAIL rmid_pre: got ret=%0d idx=%0d busy=%b want 3/2/1", retired, phase_idx, busy);
      end
      #2 rstn = 1'b0;
      #1;
      n_checks++; if ({phase_en, phase_idx, busy, halted, timeout_err} !== 8'd0 || retired !== 4'd0) begin
         n_fail++; $display("FAIL rmid_async: got en=%b idx=%0d busy=%b ret=%0d want all 0", phase_en, phase_idx, busy, retired);
      end
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      n_checks++; if (phase_en !== 3'b001) begin n_fail++; $display("FAIL rmid_restart: got %b want 001", phase_en); end
   endtask

   task automatic test_wrap();
      do_reset();
      dly_mode = 1; fix_dly = 1; run = 1'b1;
      for (int t = 1; t <= 125; t++) begin
         @(negedge clk);
         if (t == 119) begin
            n_checks++; if (retired !== 4'd0) begin n_fail++; $display("FAIL wrap_16: got %0d want 0", retired); end
         end
         if (t == 120) begin
            n_checks++; if (retired !== 4'd1) begin n_fail++; $display("FAIL wrap_17: got %0d want 1", retired); end
         end
         if (t == 113) run = 1'b0;
      end
      n_checks++; if (busy !== 1'b0 || phase_en !== 3'b000 || retired !== 4'd1) begin
         n_fail++; $display("FAIL wrap_end: got busy=%b en=%b ret=%0d want 0/000/1", busy, phase_en, retired);
      end
   endtask

   initial begin
      rstn = 1'b1; run = 1'b0; step_mode = 1'b0; step = 1'b0; clr = 1'b0; exit_req = 1'b0;
      test_reset();
      test_free_run();
      repeat (4) test_random_run();
      test_step_mode();
      test_exit();
      test_timeout();
      test_reset_mid();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
